iact_addr_sram_arbiter: RTL

//  Sequences one iact address SRAM: runs the fill (write) phase, then shares its single read

---
 rtl/iact_addr_sram_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/iact_addr_sram_arbiter.sv
// Fill sequencer plus round-robin read-port arbiter for one iact address SRAM; data path is 0-latency.
// rsp_ready of the granted requester drives sram_out_ready directly, so back-pressure reaches the SRAM.
// Optional IACT_ARB_TIMEOUT_EN aborts a read that sees no sram_out_valid for TIMEOUT_CYCLES cycles.
module iact_addr_sram_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int STREAM_W       = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        fill_start,
    output logic                        fill_done,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*STREAM_W-1:0] req_stream,
    output logic [NUM_REQ-1:0]          req_grant,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [6:0]                  rsp_data,
    output logic [NUM_REQ-1:0]          rsp_done,
    output logic                        rsp_err,
    output logic                        sram_write_en,
    input  logic                        sram_write_done,
    output logic                        sram_read_en,
    output logic [9:0]                  sram_read_addr,
    output logic                        sram_out_ready,
    input  logic                        sram_out_valid,
    input  logic [6:0]                  sram_out_data,
    input  logic                        sram_read_done
);
    localparam int IdxW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || STREAM_W < 1 || STREAM_W > 10 || TIMEOUT_CYCLES < 2) begin : gBadParams
        $error("iact_addr_sram_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, FILL, ARB, READ, RELEASE} state_t;

    state_t              state, stateNext;
    logic [IdxW-1:0]     rrPtr, grantIdx, pickIdx;
    logic [STREAM_W-1:0] streamId;
    logic                fillPending, fillDone;
    logic                anyReq, timeoutHit, readEnd;
    logic [STREAM_W-1:0] reqStreams [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : gStreams
        assign reqStreams[g] = req_stream[g*STREAM_W +: STREAM_W];
    end

    // Walk offsets from the far end down so the requester nearest rrPtr wins.
    always_comb begin
        int              cand;
        logic [IdxW-1:0] candIdx;
        cand    = 0;
        candIdx = '0;
        pickIdx = rrPtr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = int'(rrPtr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            candIdx = IdxW'(cand);
            if (req_valid[candIdx]) pickIdx = candIdx;
        end
    end

    assign anyReq = |req_valid;

`ifdef IACT_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] stallCnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stallCnt <= '0;
        end else if (state != READ || sram_out_valid) begin
            stallCnt <= '0;
        end else begin
            stallCnt <= stallCnt + CntW'(1);
        end
    end

    assign timeoutHit = (state == READ) && !sram_out_valid && (stallCnt == CntW'(TIMEOUT_CYCLES - 1));
    assign rsp_err    = timeoutHit && !sram_read_done;
`else
    assign timeoutHit = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    assign readEnd       = (state == READ) && (sram_read_done || timeoutHit);
    assign fill_done     = fillDone;
    assign sram_write_en = (state == FILL);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rrPtr       <= '0;
            grantIdx    <= '0;
            streamId    <= '0;
            fillPending <= 1'b0;
            fillDone    <= 1'b0;
        end else begin
            state    <= stateNext;
            fillDone <= (state == FILL) && sram_write_done;
            if (stateNext == FILL) begin
                fillPending <= 1'b0;
            end else if (fill_start && (state == READ || state == RELEASE)) begin
                fillPending <= 1'b1;
            end
            if (state == ARB && stateNext == READ) begin
                grantIdx <= pickIdx;
                streamId <= reqStreams[pickIdx];
            end
            if (readEnd) begin
                rrPtr <= (grantIdx == IdxW'(NUM_REQ - 1)) ? '0 : grantIdx + IdxW'(1);
            end
        end
    end

    always_comb begin
        stateNext      = state;
        req_grant      = '0;
        rsp_valid      = '0;
        rsp_done       = '0;
        rsp_data       = '0;
        sram_read_en   = 1'b0;
        sram_read_addr = '0;
        sram_out_ready = 1'b0;
        case (state)
            IDLE:    if (fill_start) stateNext = FILL;
            FILL:    if (sram_write_done) stateNext = ARB;
            ARB: begin
                if (fillPending || fill_start) stateNext = FILL;
                else if (anyReq)               stateNext = READ;
            end
            READ: begin
                req_grant[grantIdx] = 1'b1;
                sram_read_en        = 1'b1;
                sram_read_addr      = 10'(streamId);
                sram_out_ready      = rsp_ready[grantIdx];
                // The terminating zero word arrives with sram_read_done and is not forwarded.
                rsp_valid[grantIdx] = sram_out_valid & ~sram_read_done;
                rsp_data            = sram_out_data;
                rsp_done[grantIdx]  = readEnd;
                if (readEnd) stateNext = RELEASE;
            end
            RELEASE: stateNext = ARB;
            default: stateNext = IDLE;
        endcase
    end
endmodule
